// File: rtl/irq_ctrl_if.sv
// CPU-side register bus for the interrupt controller: address, write data, strobes, read data.
// Latency: none, this is only a signal bundle; read data is combinational from the slave.
// Backpressure: none, the CPU is single-cycle and every access completes in its own cycle.
interface irq_ctrl_if;
    logic [15:0] addresses;
    logic [15:0] wdata;
    logic        we;
    logic        re;
    logic [15:0] rdata;

    modport master (output addresses, output wdata, output we, output re, input rdata);
    modport slave  (input addresses, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: 8 edge/level sources, mask, fixed priority (bit 0 highest), ack/EOI FSM.
// Latency: source to int_e is 2 edges, or 4 edges when IRQ_SYNC_EN adds a 2-flop synchronizer.
// Backpressure: none; reads are combinational and writes commit on the edge that ends the access.
module irq_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'hFFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  irq_src,
    irq_ctrl_if.slave   bus,
    output logic [7:0]  int_e
);

    typedef enum logic {ST_IDLE, ST_SVC} state_t;

    state_t      state, state_nxt;
    logic [7:0]  irq_s, irq_q;
    logic [7:0]  pending, pend_nxt;
    logic [7:0]  mask, mode;
    logic [2:0]  isr_idx;
    logic        isr_load;
    logic [7:0]  int_e_nxt;
    logic [7:0]  active;
    logic        cand_vld;
    logic [2:0]  cand_idx;
    logic        sel;
    logic [1:0]  off;
    logic        wr_pend, wr_mask, wr_mode, wr_vec, rd_vec;
    logic        eoi;
    logic [7:0]  clr, rise;
    logic [15:0] vec_dat;
    logic        unused_wdata_hi;

    assign unused_wdata_hi = ^bus.wdata[15:8];

`ifdef IRQ_SYNC_EN
    logic [7:0] sync1, sync2;

    // Two-flop synchronizer so asynchronous sources can be sampled safely.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = irq_src;
`endif

    // Register window decode; the window is 4-aligned so only the top 14 bits matter.
    assign sel     = (bus.addresses[15:2] == BASE_ADDR[15:2]);
    assign off     = bus.addresses[1:0];
    assign wr_pend = sel && bus.we && (off == 2'd0);
    assign wr_mask = sel && bus.we && (off == 2'd1);
    assign wr_mode = sel && bus.we && (off == 2'd2);
    assign wr_vec  = sel && bus.we && (off == 2'd3);
    assign rd_vec  = sel && bus.re && (off == 2'd3);

    // EOI only means something while a request is in service.
    assign eoi  = wr_vec && (state == ST_SVC);
    assign clr  = (wr_pend ? bus.wdata[7:0] : 8'h00) | (eoi ? (8'b1 << isr_idx) : 8'h00);
    assign rise = irq_s & ~irq_q;

    // Edge bits: a new rising edge beats any clear in the same cycle. Level bits follow the source.
    assign pend_nxt = (mode & (rise | (pending & ~clr))) | (~mode & irq_s);

    assign active = pending & mask;

    // Fixed priority: scanning downwards leaves the lowest active index as the winner.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                cand_vld = 1'b1;
                cand_idx = i[2:0];
            end
        end
    end

    // Service FSM next state: IDLE drives the candidate, a VEC read acknowledges, EOI returns.
    always_comb begin
        state_nxt = state;
        isr_load  = 1'b0;
        int_e_nxt = 8'h00;
        case (state)
            ST_IDLE: begin
                int_e_nxt = cand_vld ? (8'b1 << cand_idx) : 8'h00;
                if (rd_vec && cand_vld) begin
                    state_nxt = ST_SVC;
                    isr_load  = 1'b1;
                end
            end
            ST_SVC: begin
                if (wr_vec) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Service FSM state, in-service index and the registered request to the CPU.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            isr_idx <= 3'd0;
            int_e   <= 8'h00;
        end else begin
            state <= state_nxt;
            int_e <= int_e_nxt;
            if (isr_load) begin
                isr_idx <= cand_idx;
            end
        end
    end

    // Pending, sampled-source history and the software-visible configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= 8'h00;
            pending <= 8'h00;
            mask    <= 8'h00;
            mode    <= 8'hFF;
        end else begin
            irq_q   <= irq_s;
            pending <= pend_nxt;
            if (wr_mask) begin
                mask <= bus.wdata[7:0];
            end
            if (wr_mode) begin
                mode <= bus.wdata[7:0];
            end
        end
    end

    // VEC contents: in service reports the latched index, otherwise the live candidate or zero.
    always_comb begin
        vec_dat = 16'h0000;
        if (state == ST_SVC) begin
            vec_dat = {2'b11, 11'b0, isr_idx};
        end else if (cand_vld) begin
            vec_dat = {2'b10, 11'b0, cand_idx};
        end
    end

    // Combinational read mux; zero unless the window is selected with a read strobe.
    always_comb begin
        bus.rdata = 16'h0000;
        if (sel && bus.re) begin
            case (off)
                2'd0:    bus.rdata = {8'h00, pending};
                2'd1:    bus.rdata = {8'h00, mask};
                2'd2:    bus.rdata = {8'h00, mode};
                default: bus.rdata = vec_dat;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomized plus directed bench for irq_ctrl with a behavioural reference model and scoreboard.
// Latency: expected read data and int_e are pushed each cycle and popped on the falling edge.
// Backpressure: none; the bench drives one bus access per cycle.
module tb_irq_ctrl;

    localparam logic [15:0] BASE = 16'hFFF0;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_src;
    logic [7:0] int_e;

    irq_ctrl_if bus();

    irq_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .bus     (bus.slave),
        .int_e   (int_e)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rdata;
        logic [7:0]  int_e;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: what the controller should hold after the latest edge.
    bit [7:0] m_pend, m_mask, m_mode, m_prev, m_s1, m_s2, m_int;
    bit       m_svc;
    int       m_isr;
    bit       m_known = 1'b0;
    bit [7:0] src_v = 8'h00;

    // Predict this cycle's outputs, queue them, then advance the model across the next edge.
    task automatic model_step(input bit r, input bit [15:0] a, input bit [15:0] d,
                              input bit w, input bit rd);
        bit [7:0]  s;
        bit [7:0]  np;
        int        cand;
        bit        in_win;
        int        offs;
        bit        eoi;
        bit        clr_w1c;
        bit [15:0] exp_rd;
        exp_t      e;

        cand = -1;
        for (int i = 0; i < 8; i++) begin
            if (cand < 0 && m_pend[i] && m_mask[i]) cand = i;
        end
        in_win = (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + 3);
        offs   = int'(a) - int'(BASE);

        if (m_known) begin
            exp_rd = 16'h0000;
            if (rd && in_win) begin
                case (offs)
                    0: exp_rd = {8'h00, m_pend};
                    1: exp_rd = {8'h00, m_mask};
                    2: exp_rd = {8'h00, m_mode};
                    default: begin
                        if (m_svc)         exp_rd = 16'hC000 + 16'(m_isr);
                        else if (cand >= 0) exp_rd = 16'h8000 + 16'(cand);
                    end
                endcase
            end
            e.rdata = exp_rd;
            e.int_e = m_int;
            sb_q.push_back(e);
        end

        if (r) begin
            m_pend = 8'h00; m_mask = 8'h00; m_mode = 8'hFF; m_prev = 8'h00;
            m_s1 = 8'h00;   m_s2 = 8'h00;   m_int = 8'h00;
            m_svc = 1'b0;   m_isr = 0;      m_known = 1'b1;
        end else begin
`ifdef IRQ_SYNC_EN
            s = m_s2;
`else
            s = src_v;
`endif
            eoi = m_svc && w && in_win && (offs == 3);
            for (int i = 0; i < 8; i++) begin
                clr_w1c = w && in_win && (offs == 0) && d[i];
                if (!m_mode[i])                 np[i] = s[i];
                else if (s[i] && !m_prev[i])    np[i] = 1'b1;
                else if (clr_w1c)               np[i] = 1'b0;
                else if (eoi && m_isr == i)     np[i] = 1'b0;
                else                            np[i] = m_pend[i];
            end
            if (m_svc)          m_int = 8'h00;
            else if (cand >= 0) m_int = 8'h01 << cand;
            else                m_int = 8'h00;
            if (!m_svc && rd && in_win && offs == 3 && cand >= 0) begin
                m_svc = 1'b1;
                m_isr = cand;
            end else if (eoi) begin
                m_svc = 1'b0;
            end
            if (w && in_win && offs == 1) m_mask = d[7:0];
            if (w && in_win && offs == 2) m_mode = d[7:0];
            m_pend = np;
            m_prev = s;
            m_s2   = m_s1;
            m_s1   = src_v;
        end
    endtask

    // Drive one bus cycle just after the rising edge and feed the model the same inputs.
    task automatic cyc(input bit r, input bit [15:0] a, input bit [15:0] d,
                       input bit w, input bit rd);
        @(posedge clk);
        #1;
        reset         = r;
        irq_src       = src_v;
        bus.addresses = a;
        bus.wdata     = d;
        bus.we        = w;
        bus.re        = rd;
        model_step(r, a, d, w, rd);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic wr(input int offs, input bit [15:0] d);
        cyc(1'b0, 16'(int'(BASE) + offs), d, 1'b1, 1'b0);
    endtask

    task automatic rdr(input int offs);
        cyc(1'b0, 16'(int'(BASE) + offs), 16'h0000, 1'b0, 1'b1);
    endtask

    // Monitor: mid-cycle, compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (bus.rdata !== e.rdata) begin
                    n_fail++;
                    $display("FAIL rdata t=%0t addr=%h re=%b got=%h exp=%h",
                             $time, bus.addresses, bus.re, bus.rdata, e.rdata);
                end
                n_checks++;
                if (int_e !== e.int_e) begin
                    n_fail++;
                    $display("FAIL int_e t=%0t got=%h exp=%h", $time, int_e, e.int_e);
                end
            end
        end
    end

    // Stimulus: directed scenarios first, then a long randomized run.
    initial begin
        int op;
        int offs;
        reset = 1'b1; irq_src = 8'h00;
        bus.addresses = 16'h0000; bus.wdata = 16'h0000; bus.we = 1'b0; bus.re = 1'b0;

        cyc(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        cyc(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Reset values of all four registers.
        rdr(0); rdr(1); rdr(2); rdr(3);

        // Single edge source through ack and EOI.
        wr(1, 16'h000C);
        src_v = 8'h08; idle(1);
        src_v = 8'h00; idle(4);
        rdr(0); rdr(3); idle(2); rdr(3); wr(3, 16'h1234); rdr(0); idle(2);

        // Two simultaneous sources: priority, then the next one after EOI.
        wr(1, 16'h00FF);
        src_v = 8'h24; idle(5);
        rdr(3); idle(2); wr(3, 16'h0000); idle(3);
        rdr(3); idle(2); wr(3, 16'h0000); idle(3);
        src_v = 8'h00; idle(2);

        // Level source ignores W1C and EOI and follows the line.
        wr(2, 16'h00FE); wr(1, 16'h0001);
        src_v = 8'h01; idle(4);
        rdr(0); wr(0, 16'h0001); rdr(0);
        rdr(3); wr(3, 16'h0000); rdr(0);
        src_v = 8'h00; idle(3); rdr(0);
        wr(2, 16'h00FF);

        // Edge on source 4 in the same cycle as its W1C: the set wins.
        wr(1, 16'h0010); idle(3);
        src_v = 8'h10;
`ifdef IRQ_SYNC_EN
        idle(2);
`endif
        wr(0, 16'h0010); rdr(0); idle(3);
        src_v = 8'h00;
        wr(0, 16'h0010); rdr(0);

        // Reset while in service; a held source reappears as a fresh edge afterwards.
        wr(1, 16'h00FF);
        src_v = 8'h02; idle(5);
        rdr(3); idle(1);
        cyc(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        rdr(3); rdr(1); wr(1, 16'h00FF); idle(5); rdr(0); rdr(3);
        src_v = 8'h00; idle(2);

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 5) == 0) src_v = src_v ^ (8'($urandom) & 8'($urandom));
            op = int'($urandom_range(0, 99));
            offs = ($urandom_range(0, 1) == 0) ? 3 : int'($urandom_range(0, 3));
            if (op < 35) begin
                idle(1);
            end else if (op < 65) begin
                rdr(offs);
            end else if (op < 94) begin
                wr(offs, 16'($urandom));
            end else if (op < 97) begin
                cyc(1'b0, 16'hFFEF, 16'($urandom), $urandom_range(0, 1) == 1, 1'b1);
            end else if (op < 99) begin
                cyc(1'b0, 16'hFFF4, 16'($urandom), 1'b1, 1'b1);
            end else begin
                cyc(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
            end
        end

        idle(2);
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller that sits directly upstream of the single-cycle CPU and drives its 8-bit `int_e` input. It samples eight external request lines, latches them as edge- or level-triggered pending bits, applies a mask, and presents the single highest-priority unmasked request one-hot on `int_e`. It exposes pending, mask, mode and vector/EOI registers on the CPU address/data bus, and sequences acknowledge and end-of-interrupt through a small service state machine.

## Interface
- `BASE_ADDR`, 16'hFFF0: base of the 4-word register window (offsets 0–3); must be 4-aligned.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `irq_src`  in  8  external request lines; bit 0 is highest priority.
- `addresses`  in  16  CPU address bus.
- `wdata`  in  16  CPU write data, already resolved from the bidirectional bus by the system top.
- `we`  in  1  write strobe, qualified by address match.
- `re`  in  1  read strobe, qualified by address match.
- `rdata`  out  16  read data; combinational; 16'h0000 when not selected or `re`=0.
- `int_e`  out  8  registered one-hot interrupt request to the CPU; reset 8'h00.

## Operation
- Register map (offset from `BASE_ADDR`; bits 15:8 read 0, ignored on write):
  - 0 PEND: read pending[7:0]; write-1-to-clear, edge-mode bits only. Reset 0.
  - 1 MASK: R/W, 1 = enabled. Reset 8'h00.
  - 2 MODE: R/W, 1 = edge (rising), 0 = level. Reset 8'hFF.
  - 3 VEC: read {valid[15], insvc[14], 11'b0, idx[2:0]}; write any value = EOI.
- Sampled source `irq_s` = `irq_src` (or synchronized copy, see Configuration); previous sample `irq_q`, reset 0.
- Edge bit: pending set when `irq_s`=1 and `irq_q`=0; cleared only by PEND W1C or EOI on that index.
- Level bit: pending <= `irq_s` every cycle; W1C and EOI have no effect.
- Set and clear of the same bit in one cycle: set wins.
- Candidate = lowest index i with pending[i] & mask[i]; valid if any.
- States:
  - IDLE: `int_e` <= one-hot(candidate), or 0 if none. VEC read returns {valid, 0, …, idx}. VEC read with valid=1 latches `isr_idx` <= idx and moves to SVC. VEC read with valid=0 returns 16'h0000 and stays in IDLE. EOI write in IDLE is ignored.
  - SVC: `int_e` <= 0. VEC read returns {1, 1, 11'b0, isr_idx}, no transition. EOI write clears pending[isr_idx] (if edge mode and not set that cycle) and moves to IDLE.
- MASK/MODE writes in SVC do not affect `isr_idx`. Writes to MODE take effect at the next edge; switching a bit edge→level reloads it from `irq_s` on the next cycle.
- Accesses outside the window: no effect; `rdata` = 0.

## Timing
- Register writes commit on the rising edge with `we`=1; reads are combinational in the same cycle, since the CPU is single-cycle.
- The VEC read side effect (IDLE→SVC) commits on the edge ending the read cycle.
- Source rising before edge k → pending visible after edge k → `int_e` asserted after edge k+1 (2-edge latency; 4 with sync).
- EOI at edge k → state IDLE after k; the next candidate appears on `int_e` after edge k+1.
- `reset` at any edge, including mid-SVC: state IDLE, all registers to reset values, `int_e`=0, sync/sample flops 0. A source held high through reset registers as a new edge afterwards.

## Configuration
- `IRQ_SYNC_EN` defined: two-flop synchronizer (reset 0) on each `irq_src` bit before edge detection; adds 2 cycles of latency; sources may be asynchronous.
- Undefined: `irq_s` = `irq_src` directly; sources must be synchronous to `clk`.

## Test plan
- Reset, then read offsets 0–3 → 0x0000, 0x0000, 0x00FF, 0x0000; `int_e`=0.
- MASK=0x0C, pulse `irq_src[3]` one cycle → PEND=0x08, `int_e`=0x08 two edges later; read VEC → 0x8003, then `int_e`=0 and VEC reads 0xC003; write VEC → PEND=0x00, IDLE.
- MASK=0xFF, raise sources 5 and 2 together → `int_e`=0x04; ack + EOI → `int_e`=0x20 one edge after the EOI.
- MODE=0xFE, MASK=0x01, hold `irq_src[0]` high → PEND bit0=1; W1C 0x01 and EOI do not clear it; drop the source → PEND=0 the next cycle.
- Edge on source 4 in the same cycle as a W1C of 0x10 → PEND bit4 remains 1.
- Assert `reset` while in SVC → `int_e`=0, VEC=0x0000, MASK=0; with `IRQ_SYNC_EN` defined, source-to-`int_e` latency measures 4 edges.
